// File: rtl/decodificador_segmentos.sv
// decodificador_segmentos: receive side of the 7-segment status link.
// Synchronises the asynchronous segment lines, waits for a stable pattern,
// decodes the four legal glyphs into {y1,y0}, flags illegal patterns and
// counts accepted code changes.
// Optional build macro DECOD_CONTADOR_ERROS_EN adds the cont_erros output,
// a saturating count of erro pulses.
//
// state    | meaning
// ---------+-----------------------------------------------
// ESPERA   | no code shown yet, or blank pattern held
// ESTAVEL  | legal code held, {y1,y0} valid
// INVALIDO | illegal pattern held, {y1,y0} keep last code
module decodificador_segmentos #(
   parameter int ESTAVEL_CICLOS = 4,
   parameter int CONT_W         = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seg_a,
   input  logic              seg_b,
   input  logic              seg_c,
   input  logic              seg_d,
   input  logic              seg_e,
   input  logic              seg_f,
   input  logic              seg_g,
   output logic              y1,
   output logic              y0,
   output logic              valido,
   output logic              novo,
   output logic              erro,
   output logic [CONT_W-1:0] cont_trocas
`ifdef DECOD_CONTADOR_ERROS_EN
   ,
   output logic [CONT_W-1:0] cont_erros
`endif
);

   localparam logic [3:0] C_ALVO = 4'(ESTAVEL_CICLOS);

   localparam logic [6:0] GLIFO_00    = 7'b0001100;
   localparam logic [6:0] GLIFO_01    = 7'b1111010;
   localparam logic [6:0] GLIFO_10    = 7'b1111100;
   localparam logic [6:0] GLIFO_11    = 7'b1110011;
   localparam logic [6:0] GLIFO_BLANK = 7'b0000000;

   typedef enum logic [1:0] {
      ESPERA   = 2'd0,
      ESTAVEL  = 2'd1,
      INVALIDO = 2'd2
   } estado_t;

   logic [6:0]        w_p;
   logic [6:0]        r_sinc1;
   logic [6:0]        r_sinc2;
   logic [3:0]        r_cont;
   logic [3:0]        w_cont_prox;
   logic              w_igual;
   logic              w_aceita;
   logic              w_legal;
   logic              w_branco;
   logic [1:0]        w_codigo;
   estado_t           r_estado;
   logic [1:0]        r_y;
   logic              r_valido;
   logic              r_novo;
   logic              r_erro;
   logic [CONT_W-1:0] r_trocas;

   assign w_p = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

   // Two-stage synchroniser on the whole bus; r_sinc2 is the sampled pattern S.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sinc1 <= '0;
         r_sinc2 <= '0;
      end else begin
         r_sinc1 <= w_p;
         r_sinc2 <= r_sinc1;
      end
   end

   // r_sinc1 is the value S takes next edge, so comparing the two stages tells
   // whether S is about to change; this keeps the acceptance on the 6th edge.
   assign w_igual     = (r_sinc1 == r_sinc2);
   assign w_cont_prox = !w_igual ? 4'd0 :
                        (r_cont == C_ALVO) ? r_cont : r_cont + 4'd1;
   assign w_aceita    = (w_cont_prox == C_ALVO) && (r_cont != C_ALVO);

   // Stability counter: clears on any change of S, saturates at the target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cont <= '0;
      end else begin
         r_cont <= w_cont_prox;
      end
   end

   // Glyph decode of the pattern that is stable in the synchroniser.
   always_comb begin
      w_legal  = 1'b1;
      w_branco = 1'b0;
      w_codigo = 2'b00;
      case (r_sinc1)
         GLIFO_00:    w_codigo = 2'b00;
         GLIFO_01:    w_codigo = 2'b01;
         GLIFO_10:    w_codigo = 2'b10;
         GLIFO_11:    w_codigo = 2'b11;
         GLIFO_BLANK: begin
            w_legal  = 1'b0;
            w_branco = 1'b1;
         end
         default:     w_legal = 1'b0;
      endcase
   end

   // Display state machine with registered outputs; acts only on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado <= ESPERA;
         r_y      <= 2'b00;
         r_valido <= 1'b0;
         r_novo   <= 1'b0;
         r_erro   <= 1'b0;
         r_trocas <= '0;
      end else begin
         r_novo <= 1'b0;
         r_erro <= 1'b0;
         if (w_aceita) begin
            if (w_legal) begin
               // Re-showing the held code after blank/illegal still counts.
               if (r_estado != ESTAVEL || w_codigo != r_y) begin
                  r_estado <= ESTAVEL;
                  r_y      <= w_codigo;
                  r_valido <= 1'b1;
                  r_novo   <= 1'b1;
                  if (r_trocas != {CONT_W{1'b1}}) begin
                     r_trocas <= r_trocas + 1'b1;
                  end
               end
            end else if (w_branco) begin
               r_estado <= ESPERA;
               r_valido <= 1'b0;
            end else begin
               r_estado <= INVALIDO;
               r_valido <= 1'b0;
               r_erro   <= 1'b1;
            end
         end
      end
   end

`ifdef DECOD_CONTADOR_ERROS_EN
   logic [CONT_W-1:0] r_erros;

   // Saturating count of illegal acceptances, stepped with the erro pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_erros <= '0;
      end else if (w_aceita && !w_legal && !w_branco &&
                   r_erros != {CONT_W{1'b1}}) begin
         r_erros <= r_erros + 1'b1;
      end
   end

   assign cont_erros = r_erros;
`endif

   assign y1          = r_y[1];
   assign y0          = r_y[0];
   assign valido      = r_valido;
   assign novo        = r_novo;
   assign erro        = r_erro;
   assign cont_trocas = r_trocas;

endmodule

// File: tb/tb_decodificador_segmentos.sv
// Bench for decodificador_segmentos: directed scenarios with literal
// expectations followed by randomized patterns, all outputs compared every
// cycle against a windowed behavioural model. A second instance with
// CONT_W=2 shares the stimulus to exercise counter saturation.
module tb_decodificador_segmentos;

   localparam int E = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] pins = 7'd0;

   logic       y1, y0, valido, novo, erro;
   logic [7:0] cont_trocas;
   logic       b_y1, b_y0, b_valido, b_novo, b_erro;
   logic [1:0] b_cont;
`ifdef DECOD_CONTADOR_ERROS_EN
   logic [7:0] cont_erros;
   logic [1:0] b_cont_erros;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decodificador_segmentos #(.ESTAVEL_CICLOS(E), .CONT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .seg_a(pins[6]), .seg_b(pins[5]), .seg_c(pins[4]), .seg_d(pins[3]),
      .seg_e(pins[2]), .seg_f(pins[1]), .seg_g(pins[0]),
      .y1(y1), .y0(y0), .valido(valido), .novo(novo), .erro(erro),
      .cont_trocas(cont_trocas)
`ifdef DECOD_CONTADOR_ERROS_EN
      , .cont_erros(cont_erros)
`endif
   );

   decodificador_segmentos #(.ESTAVEL_CICLOS(E), .CONT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .seg_a(pins[6]), .seg_b(pins[5]), .seg_c(pins[4]), .seg_d(pins[3]),
      .seg_e(pins[2]), .seg_f(pins[1]), .seg_g(pins[0]),
      .y1(b_y1), .y0(b_y0), .valido(b_valido), .novo(b_novo), .erro(b_erro),
      .cont_trocas(b_cont)
`ifdef DECOD_CONTADOR_ERROS_EN
      , .cont_erros(b_cont_erros)
`endif
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // S(n) is the pin value sampled one edge earlier (0 right after reset).
   // A pattern is accepted on the first edge where the last E+1 values of S
   // are all equal.
   logic [6:0] sq[$];
   logic [6:0] last_samp;
   logic [1:0] m_y;
   bit         m_est, m_novo, m_erro;
   int         m_cnt, m_ecnt;

   function automatic int classify(input logic [6:0] p, output logic [1:0] code);
      code = 2'b00;
      case (p)
         7'b0001100: begin code = 2'd0; return 0; end
         7'b1111010: begin code = 2'd1; return 0; end
         7'b1111100: begin code = 2'd2; return 0; end
         7'b1110011: begin code = 2'd3; return 0; end
         7'b0000000: return 1;
         default:    return 2;
      endcase
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq.delete();
         sq.push_back(7'd0);
         last_samp = 7'd0;
         m_y = 2'b00; m_est = 0; m_novo = 0; m_erro = 0;
         m_cnt = 0; m_ecnt = 0;
      end else begin
         int  L;
         bit  now_ok, prev_ok;
         int  kind;
         logic [1:0] code;
         m_novo = 0;
         m_erro = 0;
         sq.push_back(last_samp);
         last_samp = pins;
         if (sq.size() > E + 2) void'(sq.pop_front());
         L = sq.size();
         now_ok = (L >= E + 1);
         if (now_ok)
            for (int i = L - E - 1; i < L; i++) if (sq[i] != sq[L-1]) now_ok = 0;
         prev_ok = (L >= E + 2);
         if (prev_ok)
            for (int i = L - E - 2; i < L - 1; i++) if (sq[i] != sq[L-2]) prev_ok = 0;
         if (now_ok && !prev_ok) begin
            kind = classify(sq[L-1], code);
            if (kind == 0) begin
               if (!m_est || code != m_y) begin
                  m_y = code; m_est = 1; m_novo = 1; m_cnt++;
               end
            end else if (kind == 1) begin
               m_est = 0;
            end else begin
               m_est = 0; m_erro = 1; m_ecnt++;
            end
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      chk("y1y0", {y1, y0}, m_y);
      chk("valido", valido, m_est);
      chk("novo", novo, m_novo);
      chk("erro", erro, m_erro);
      chk("cont_trocas", cont_trocas, sat(m_cnt, 255));
      chk("w2_y1y0", {b_y1, b_y0}, m_y);
      chk("w2_novo", b_novo, m_novo);
      chk("w2_cont_trocas", b_cont, sat(m_cnt, 3));
`ifdef DECOD_CONTADOR_ERROS_EN
      chk("cont_erros", cont_erros, sat(m_ecnt, 255));
      chk("w2_cont_erros", b_cont_erros, sat(m_ecnt, 3));
`endif
   end

   task automatic hold_p(input logic [6:0] p, input int n);
      pins = p;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int kind;
      int dur;
      repeat (3) @(negedge clk);
      chk("rst_valido", valido, 0);
      chk("rst_cont", cont_trocas, 0);

      // Release with code 01 held: outputs appear on the 6th edge.
      rst_n = 1'b1;
      pins  = 7'b1111010;
      repeat (5) @(negedge clk);
      chk("lat_edge5_valido", valido, 0);
      @(negedge clk);
      chk("lat_edge6_y", {y1, y0}, 1);
      chk("lat_edge6_valido", valido, 1);
      chk("lat_edge6_novo", novo, 1);
      chk("lat_edge6_cont", cont_trocas, 1);
      @(negedge clk);
      chk("lat_edge7_novo", novo, 0);
      hold_p(7'b1111010, 8);
      chk("hold_cont", cont_trocas, 1);

      hold_p(7'b0001100, 10);
      chk("seq_y00", {y1, y0}, 0);
      hold_p(7'b1111100, 10);
      chk("seq_y10", {y1, y0}, 2);
      hold_p(7'b1110011, 10);
      chk("seq_y11", {y1, y0}, 3);
      chk("seq_cont", cont_trocas, 4);

      hold_p(7'b1111010, 10);
      chk("sat_w2_cont", b_cont, 3);
      hold_p(7'b1111100, 2);
      hold_p(7'b1111010, 10);
      chk("glitch_y", {y1, y0}, 1);
      chk("glitch_cont", cont_trocas, 5);

      hold_p(7'b1111100, 10);
      hold_p(7'b1010101, 10);
      chk("illegal_valido", valido, 0);
      chk("illegal_y", {y1, y0}, 2);
      hold_p(7'b1111100, 10);
      chk("after_illegal_valido", valido, 1);
      chk("after_illegal_cont", cont_trocas, 7);

      hold_p(7'b1110011, 10);
      hold_p(7'b0000000, 10);
      chk("blank_valido", valido, 0);
      hold_p(7'b1110011, 10);
      chk("after_blank_cont", cont_trocas, 9);

      // Reset in the middle of a debounce window.
      pins = 7'b1111010;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_y", {y1, y0}, 0);
      chk("midrst_valido", valido, 0);
      chk("midrst_cont", cont_trocas, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("postrst_edge5_valido", valido, 0);
      @(negedge clk);
      chk("postrst_edge6_novo", novo, 1);
      chk("postrst_edge6_cont", cont_trocas, 1);

      // Randomized patterns, glitches and occasional resets.
      for (int it = 0; it < 400; it++) begin
         kind = $urandom_range(0, 19);
         dur  = $urandom_range(1, 9);
         if (kind < 12) begin
            case ($urandom_range(0, 3))
               0: hold_p(7'b0001100, dur);
               1: hold_p(7'b1111010, dur);
               2: hold_p(7'b1111100, dur);
               default: hold_p(7'b1110011, dur);
            endcase
         end else if (kind < 14) begin
            hold_p(7'b0000000, dur);
         end else if (kind < 19) begin
            hold_p(7'($urandom_range(0, 127)), dur);
         end else begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      repeat (10) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
